// File: rtl/mux_arbiter_pkg.sv
// Shared switch constants: port count, port order and priority width.
// Also carries the round-robin pointer wrap helper.
package mux_arbiter_pkg;

  localparam int NUM_PORTS      = 7;
  localparam int PRIORITY_WIDTH = 8;
  localparam int IDX_WIDTH      = 3;

  typedef enum logic [IDX_WIDTH-1:0] {
    LOCAL = 3'd0,
    YNEG  = 3'd1,
    YPOS  = 3'd2,
    XPOS  = 3'd3,
    XNEG  = 3'd4,
    ZPOS  = 3'd5,
    ZNEG  = 3'd6
  } port_e;

  function automatic logic [IDX_WIDTH-1:0] wrap_inc(
    input logic [IDX_WIDTH-1:0] i,
    input int                   n
  );
    if (int'(i) + 1 >= n)
      return '0;
    return i + IDX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_max_select.sv
// Rotated max-key search: largest key among valid ports,
// ties resolved by first hit scanning from start.
module rr_max_select #(
  parameter int N    = 7,
  parameter int KeyW = 9,
  parameter int IdxW = 3
) (
  input  logic [N-1:0]      valid,
  input  logic [N*KeyW-1:0] key,
  input  logic [IdxW-1:0]   start,
  output logic [IdxW-1:0]   idx,
  output logic              found
);

  logic [KeyW-1:0] best;
  int              p;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    best  = '0;
    p     = 0;
    // strict compare keeps the earliest port in rotated order on ties
    for (int k = 0; k < N; k++) begin
      p = int'(start) + k;
      if (p >= N)
        p = p - N;
      if (valid[p] &&
          (!found || key[p*KeyW +: KeyW] > best)) begin
        found = 1'b1;
        best  = key[p*KeyW +: KeyW];
        idx   = IdxW'(p);
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Output-port arbiter: priority with starvation aging and
// round-robin tie break; grants in the same cycle as requests.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int NumPorts      = NUM_PORTS,
  parameter int PriorityWidth = PRIORITY_WIDTH,
  parameter int AgeWidth      = 4,
  parameter int AgeLimit      = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NumPorts-1:0]               req_valid,
  input  logic [NumPorts*PriorityWidth-1:0] req_prio,
  input  logic                              out_ready,
  output logic [NumPorts-1:0]               grant,
  output logic                              grant_valid,
  output logic [IDX_WIDTH-1:0]              grant_idx
);

  localparam int KeyW = PriorityWidth + 1;

  logic [IDX_WIDTH-1:0]     rr_ptr;
  logic [AgeWidth-1:0]      age [NumPorts];
  logic [NumPorts-1:0]      starved;
  logic [NumPorts*KeyW-1:0] key;
  logic [IDX_WIDTH-1:0]     sel_idx;
  logic                     found;
  logic                     fire;

  for (genvar i = 0; i < NumPorts; i++) begin : g_key
    assign starved[i] = (age[i] == AgeWidth'(AgeLimit));
    assign key[i*KeyW +: KeyW] =
      {starved[i], req_prio[i*PriorityWidth +: PriorityWidth]};
  end

  rr_max_select #(
    .N    (NumPorts),
    .KeyW (KeyW),
    .IdxW (IDX_WIDTH)
  ) u_sel (
    .valid (req_valid),
    .key   (key),
    .start (rr_ptr),
    .idx   (sel_idx),
    .found (found)
  );

  // found is exactly |req_valid
  assign fire        = out_ready & found & ~rst;
  assign grant_valid = fire;
  assign grant_idx   = fire ? sel_idx : '0;
  assign grant       = fire ? (NumPorts'(1) << sel_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < NumPorts; i++)
        age[i] <= '0;
    end else if (fire) begin
      rr_ptr <= wrap_inc(sel_idx, NumPorts);
      for (int i = 0; i < NumPorts; i++) begin
        if (grant[i])
          age[i] <= '0;
        else if (req_valid[i])
          age[i] <= starved[i] ? age[i]
                              : age[i] + AgeWidth'(1);
        else
          age[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter with AgeLimit=3: directed
// vectors push expected grants; a negedge monitor compares.
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;

  localparam int N  = 7;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_prio;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [2:0]      grant_idx;

  always #5 clk = ~clk;

  mux_arbiter #(
    .NumPorts      (N),
    .PriorityWidth (PW),
    .AgeWidth      (4),
    .AgeLimit      (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_prio    (req_prio),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  typedef struct {
    logic       gv;
    logic [2:0] idx;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [N-1:0] eg;
      e  = q.pop_front();
      eg = e.gv ? (N'(1) << e.idx) : '0;
      checks++;
      if (grant_valid !== e.gv || grant !== eg ||
          grant_idx !== e.idx) begin
        errors++;
        $display("FAIL %s: got grant=%b gv=%b idx=%0d, want grant=%b gv=%b idx=%0d",
                 e.name, grant, grant_valid, grant_idx,
                 eg, e.gv, e.idx);
      end
    end
  end

  function automatic logic [N*PW-1:0] fill(input logic [7:0] x);
    return {N{x}};
  endfunction

  task automatic step(
    input string        name,
    input logic         r,
    input logic [N-1:0] v,
    input logic [N*PW-1:0] p,
    input logic         rdy,
    input logic         gv,
    input int           idx
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_prio  = p;
    out_ready = rdy;
    e.gv   = gv;
    e.idx  = 3'(idx);
    e.name = name;
    q.push_back(e);
  endtask

  logic [N*PW-1:0] p;
  logic [N*PW-1:0] tie;
  logic [N*PW-1:0] age_p;

  initial begin
    int w;
    rst       = 1'b1;
    req_valid = '0;
    req_prio  = '0;
    out_ready = 1'b0;
    tie       = fill(8'd5);
    age_p     = fill(8'hFF);
    age_p[0*PW +: PW] = 8'd200;
    age_p[1*PW +: PW] = 8'd1;

    // reset holds grants low even with traffic present
    step("reset0", 1, 7'h7F, tie, 1, 0, 0);
    step("reset1", 1, 7'h7F, tie, 1, 0, 0);

    // priority order, then rr_ptr=3 seen through a tie
    p = fill(8'd0);
    p[0*PW +: PW] = 8'd3;
    p[2*PW +: PW] = 8'd9;
    step("prio", 0, 7'b0000101, p, 1, 1, 2);
    step("prio_rr", 0, 7'h7F, tie, 1, 1, 3);

    // round robin on ties over 8 cycles
    step("rst_rr", 1, 7'h7F, tie, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      step("rr_tie", 0, 7'h7F, tie, 1, 1, i % 7);

    // aging: port1 starves after three losses
    step("rst_age", 1, 7'h00, tie, 1, 0, 0);
    step("age0", 0, 7'b0000011, age_p, 1, 1, 0);
    step("age1", 0, 7'b0000011, age_p, 1, 1, 0);
    step("age2", 0, 7'b0000011, age_p, 1, 1, 0);
    step("starve", 0, 7'b0000011, age_p, 1, 1, 1);
    step("age_after", 0, 7'b0000011, age_p, 1, 1, 0);

    // stall must not age port1
    step("rst_stall", 1, 7'h00, tie, 1, 0, 0);
    step("st_pre0", 0, 7'b0000011, age_p, 1, 1, 0);
    step("st_pre1", 0, 7'b0000011, age_p, 1, 1, 0);
    for (int i = 0; i < 10; i++)
      step("stall", 0, 7'h7F, age_p, 0, 0, 0);
    step("st_post0", 0, 7'b0000011, age_p, 1, 1, 0);
    step("st_post1", 0, 7'b0000011, age_p, 1, 1, 1);

    // empty input holds state; garbage prio ignored
    step("rst_empty", 1, 7'h00, tie, 1, 0, 0);
    step("em0", 0, 7'b0000011, age_p, 1, 1, 0);
    step("empty", 0, 7'h00, fill(8'hFF), 1, 0, 0);
    step("em1", 0, 7'b0000011, age_p, 1, 1, 0);
    step("em2", 0, 7'b0000011, age_p, 1, 1, 0);
    step("em_starve", 0, 7'b0000011, age_p, 1, 1, 1);
    p = fill(8'hFF);
    p[0*PW +: PW] = 8'd0;
    step("garbage", 0, 7'b0000001, p, 1, 1, 0);

    // reset in the middle of tie traffic at rr_ptr=4
    step("rst_mid0", 1, 7'h7F, tie, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      step("mid_tie", 0, 7'h7F, tie, 1, 1, i);
    step("mid_rst", 1, 7'h7F, tie, 1, 0, 0);
    step("post_rst0", 0, 7'h7F, tie, 1, 1, 0);
    step("post_rst1", 0, 7'h7F, tie, 1, 1, 1);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 7, meaning requester count (port order: local, yneg, ypos, xpos, xneg, zpos, zneg).
REQ-002 SHALL have parameter PriorityWidth, default 8, meaning the width of each requester's priority field.
REQ-003 SHALL have parameter AgeWidth, default 4, meaning the width of each per-port starvation counter.
REQ-004 SHALL have parameter AgeLimit, default 15, meaning the age at which a port counts as starved; legal range 1..2^AgeWidth-1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, NumPorts bits: bit i set means FIFO i is non-empty.
REQ-008 SHALL have port req_prio, input, NumPorts*PriorityWidth bits: head-of-FIFO priority, port i in bits [i*PriorityWidth +: PriorityWidth].
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream pipeline can accept a flit this cycle.
REQ-010 SHALL have port grant, output, NumPorts bits: one-hot consume strobe to the FIFOs.
REQ-011 SHALL have port grant_valid, output, 1 bit: a grant is issued this cycle.
REQ-012 SHALL have port grant_idx, output, 3 bits: index of the granted port, used as the data-select for the mux.

Function
REQ-013 SHALL compute grant, grant_valid and grant_idx combinationally in the same cycle from req_valid, req_prio, out_ready and registered state (zero-cycle arbitration latency).
REQ-014 SHALL give each port an effective key {starved_i, req_prio_i} (PriorityWidth+1 bits), where starved_i = (age_i == AgeLimit).
REQ-015 SHALL select, among ports with req_valid set, the one with the largest key; a starved port therefore beats any non-starved port.
REQ-016 SHALL break key ties by round-robin: the first tied port found scanning rr_ptr, rr_ptr+1, ... modulo NumPorts wins.
REQ-017 SHALL define fire = out_ready & |req_valid & ~rst; grant_valid = fire; grant is one-hot at the selected port when fire, else all-zero.
REQ-018 SHALL drive grant_idx to the selected index when fire, else 0.
REQ-019 SHALL never assert a grant bit for a port whose req_valid is 0; no grant is issued on an empty FIFO.
REQ-020 SHALL, on a fire cycle, update rr_ptr to (grant_idx+1) mod NumPorts, wrapping from 6 to 0.
REQ-021 SHALL, on a fire cycle, update ages per port: the granted port goes to 0; a valid non-granted port increments, saturating at AgeLimit; an invalid port goes to 0.
REQ-022 SHALL hold rr_ptr and all ages unchanged while out_ready=0; stall cycles do not count as starvation.
REQ-023 SHALL hold all state unchanged when out_ready=1 and req_valid is all-zero.
REQ-024 SHALL, when several ports are starved, choose among them by req_prio and then by round-robin per REQ-015/REQ-016.
REQ-025 SHALL treat req_prio as unsigned; value 0 is a legal, lowest priority.

Reset
REQ-026 SHALL, on a clock edge with rst=1, set rr_ptr=0 and every age to 0.
REQ-027 SHALL force grant=0, grant_valid=0 and grant_idx=0 combinationally in any cycle with rst=1, including rst asserted in the middle of traffic; no FIFO is consumed during reset.
REQ-028 SHALL arbitrate normally from the first cycle after rst deasserts.

Structure
REQ-029 SHALL take NumPorts, the port-index constants (LOCAL=0 .. ZNEG=6) and PriorityWidth from the shared network package/include already used by the switch.
REQ-030 SHALL implement the rotated max-key search as one combinational sub-module, rr_max_select (inputs: valid vector, key vector, start pointer; outputs: index, found); all state stays in mux_arbiter.
REQ-031 SHALL be a drop-in replacement for the mux's tree comparator: grant feeds the FIFO consume strobes, grant_idx the data select.

Verification
REQ-032 SHALL verify priority order: valid=7'b0000101, prio0=3, prio2=9, out_ready=1 -> grant=7'b0000100, grant_idx=2, rr_ptr becomes 3.
REQ-033 SHALL verify round-robin on ties: all 7 valid, all prio=5, held for 8 cycles -> grant_idx sequence 0,1,2,3,4,5,6,0.
REQ-034 SHALL verify aging with AgeLimit=3: port1 prio=1 and port0 prio=200, both always valid -> port0 granted 3 cycles, port1 granted on cycle 4 (starved), then port0 again.
REQ-035 SHALL verify stall: out_ready=0 for 10 cycles with valid=7'h7F -> grant=0, grant_valid=0, and ages/rr_ptr unchanged afterwards (same winner as before the stall).
REQ-036 SHALL verify empty input: valid=0 with out_ready=1 -> grant_valid=0, no state change; a garbage req_prio=0xFF on an invalid port is never granted.
REQ-037 SHALL verify reset mid-run: rst=1 for 1 cycle during tie traffic with rr_ptr=4 -> grant=0 in that cycle; next cycle grant_idx=0 and all ages are 0.
